// File: rtl/rw_pkg.sv
// Shared constants, state encoding and group type for the result writer.
package rw_pkg;
  localparam int RES_W   = 18;
  localparam int LANES   = 4;
  localparam int GROUP_W = RES_W * LANES;

  typedef logic [GROUP_W-1:0] group_t;
  typedef logic [RES_W-1:0]   res_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Lane 0 (MU1) sits in the most significant slice of a group.
  function automatic res_t lane_of(input group_t grp, input logic [1:0] lane);
    return grp[(LANES - 1 - int'(lane)) * RES_W +: RES_W];
  endfunction
endpackage

// File: rtl/result_writer_if.sv
// ALU-to-writer handshake plus the output-RAM write port of the result writer.
interface result_writer_if #(
  parameter int ADDR_W = 4
) ();
  rw_pkg::res_t      MU1;
  rw_pkg::res_t      MU2;
  rw_pkg::res_t      MU3;
  rw_pkg::res_t      MU4;
  logic              web;
  logic              ALU_done;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  rw_pkg::res_t      ram_din;
  logic              wr_done;

  modport master (
    output MU1, MU2, MU3, MU4, web, ALU_done,
    input  ram_we, ram_addr, ram_din, wr_done
  );

  modport slave (
    input  MU1, MU2, MU3, MU4, web, ALU_done,
    output ram_we, ram_addr, ram_din, wr_done
  );
endinterface

// File: rtl/rw_fifo.sv
// Small synchronous FIFO of result groups; a push into a full FIFO is accepted only alongside a pop.
module rw_fifo #(
  parameter  int WIDTH = 72,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/result_writer.sv
// Result writer: buffers 4-result groups from the ALU and drains them one lane per cycle into the output RAM.
// Optional feature macro RESULT_MAX_EN: track the largest written value and its address.
module result_writer
  import rw_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  result_writer_if.slave    bus,
  output logic              busy,
  output logic              ovf,
  output res_t              max_val,
  output logic [ADDR_W-1:0] max_addr
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t            state;
  state_t            state_nxt;
  group_t            shadow_p0;
  group_t            head;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              stay;
  logic              pending;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] addr_cnt;
  res_t              lane_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  res_t              wr_data;

  assign lane_data = lane_of(head, lane);
  assign pop       = (state == DRAIN) && (lane == 2'd3);
  // After the last lane, keep draining if anything remains once the head is gone.
  assign stay      = bus.web || (count != CNT_W'(1));

  rw_fifo #(
    .WIDTH (GROUP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.web),
    .pop   (pop),
    .din   (shadow_p0),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!empty)       state_nxt = DRAIN;
        else if (pending) state_nxt = DONE;
      end
      DRAIN:   if (pop && !stay) state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Shadow stage: upstream clears MU in the web cycle, so the push takes last cycle's values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_p0 <= '0;
      pending   <= 1'b0;
      ovf       <= 1'b0;
      addr_cnt  <= '0;
      lane      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      shadow_p0 <= {bus.MU1, bus.MU2, bus.MU3, bus.MU4};
      if (bus.ALU_done)     pending <= 1'b1;
      else if (state == DONE) pending <= 1'b0;
      if (bus.web && full && !pop) ovf <= 1'b1;
      wr_en <= (state == DRAIN);
      if (state == DRAIN) begin
        wr_data  <= lane_data;
        wr_addr  <= addr_cnt;
        addr_cnt <= addr_cnt + 1'b1;
        lane     <= lane + 1'b1;
      end else if (state == DONE) begin
        addr_cnt <= '0;
      end
    end
  end

`ifdef RESULT_MAX_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_val  <= '0;
      max_addr <= '0;
    end else if (state == DONE) begin
      max_val  <= '0;
      max_addr <= '0;
    end else if ((state == DRAIN) && (lane_data > max_val)) begin
      max_val  <= lane_data;
      max_addr <= addr_cnt;
    end
  end
`else
  assign max_val  = '0;
  assign max_addr = '0;
`endif

  assign bus.ram_we   = wr_en;
  assign bus.ram_addr = wr_addr;
  assign bus.ram_din  = wr_data;
  assign bus.wr_done  = (state == DONE);
  assign busy         = !empty || (state == DRAIN);
endmodule

// File: tb/tb_result_writer.sv
// Bench for result_writer: table vectors with exact timing, directed corner sequences, randomized matrices vs a write-list model.
module tb_result_writer;
  import rw_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2;
  localparam int NV     = 6;
`ifdef RESULT_MAX_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  typedef logic [0:3][RES_W-1:0]    grp_t;
  typedef logic [ADDR_W+RES_W-1:0] wr_t;
  typedef struct {
    grp_t              mu;
    res_t              mx;
    logic [ADDR_W-1:0] ma;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              busy;
  logic              ovf;
  res_t              max_val;
  logic [ADDR_W-1:0] max_addr;

  result_writer_if #(.ADDR_W(ADDR_W)) bus ();

  result_writer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .ovf      (ovf),
    .max_val  (max_val),
    .max_addr (max_addr)
  );

  int                total;
  int                bad;
  int                n_done;
  wr_t               obs_q[$];
  wr_t               exp_q[$];
  logic [ADDR_W-1:0] m_addr;
  vec_t              vecs[NV];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  initial n_done = 0;
  always @(negedge clk) begin
    if (rst && bus.ram_we)  obs_q.push_back({bus.ram_addr, bus.ram_din});
    if (rst && bus.wr_done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic drive_mu(input grp_t g);
    bus.MU1 = g[0];
    bus.MU2 = g[1];
    bus.MU3 = g[2];
    bus.MU4 = g[3];
  endtask

  // MU valid for one cycle, then web with MU cleared, as the upstream ALU does.
  task automatic send_group(input grp_t g, input logic with_done);
    tick(); drive_mu(g);   bus.web = 1'b0;
    tick(); drive_mu('0);  bus.web = 1'b1; bus.ALU_done = with_done;
    tick(); bus.web = 1'b0; bus.ALU_done = 1'b0;
  endtask

  task automatic pulse_done();
    tick(); bus.ALU_done = 1'b1;
    tick(); bus.ALU_done = 1'b0;
  endtask

  // Model: each accepted group yields four writes in lane order at consecutive (wrapping) addresses.
  task automatic expect_group(input grp_t g);
    for (int l = 0; l < 4; l++) begin
      exp_q.push_back({m_addr, g[l]});
      m_addr = m_addr + 1'b1;
    end
  endtask

  task automatic compare_obs(input string name);
    check({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(name, 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_we"},   32'(bus.ram_we),   32'd0);
    check({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
    check({tag, "_ram_din"},  32'(bus.ram_din),  32'd0);
    check({tag, "_wr_done"},  32'(bus.wr_done),  32'd0);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_ovf"},      32'(ovf),          32'd0);
    check({tag, "_max_val"},  32'(max_val),      32'd0);
    check({tag, "_max_addr"}, 32'(max_addr),     32'd0);
  endtask

  function automatic vec_t mk(input res_t a, input res_t b, input res_t c, input res_t d,
                              input res_t mx, input logic [ADDR_W-1:0] ma);
    vec_t v;
    v.mu[0] = a; v.mu[1] = b; v.mu[2] = c; v.mu[3] = d;
    v.mx = mx;
    v.ma = ma;
    return v;
  endfunction

  function automatic grp_t rand_group();
    grp_t r;
    for (int i = 0; i < 4; i++) r[i] = RES_W'($urandom);
    return r;
  endfunction

  initial begin
    int   d0;
    int   ng;
    bit   same;
    bit   last;
    grp_t g, ga, gb, gc;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive_mu('0);
    bus.web      = 1'b0;
    bus.ALU_done = 1'b0;
    m_addr       = '0;

    // {MU1..MU4, expected max value, expected max address} with the max feature on
    vecs[0] = mk(18'd1,       18'd2,       18'd3,       18'd4,       18'd4,       4'd3);
    vecs[1] = mk(18'd5,       18'd9,       18'd9,       18'd3,       18'd9,       4'd1);
    vecs[2] = mk(18'd7,       18'd7,       18'd7,       18'd7,       18'd7,       4'd0);
    vecs[3] = mk(18'd0,       18'd0,       18'd0,       18'd0,       18'd0,       4'd0);
    vecs[4] = mk(18'h3FFFF,   18'h20000,   18'd1,       18'h3FFFF,   18'h3FFFF,   4'd0);
    vecs[5] = mk(18'h00100,   18'h3FFFE,   18'h3FFFF,   18'd2,       18'h3FFFF,   4'd2);

    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single group with ALU_done in the same cycle: exact write timing, hold, wr_done, max.
    for (int v = 0; v < NV; v++) begin
      send_group(vecs[v].mu, 1'b1);
      @(negedge clk); check("tbl_lat0", 32'(bus.ram_we), 32'd0);
      tick(); @(negedge clk);
      check("tbl_lat1", 32'(bus.ram_we), 32'd0);
      check("tbl_busy", 32'(busy), 32'd1);
      for (int l = 0; l < 4; l++) begin
        tick(); @(negedge clk);
        check("tbl_we", 32'(bus.ram_we), 32'd1);
        check("tbl_wr", 32'({bus.ram_addr, bus.ram_din}), 32'({4'(l), vecs[v].mu[l]}));
      end
      check("tbl_max_val",  32'(max_val),  MAX_EN ? 32'(vecs[v].mx) : 32'd0);
      check("tbl_max_addr", 32'(max_addr), MAX_EN ? 32'(vecs[v].ma) : 32'd0);
      tick(); @(negedge clk);
      check("tbl_we_off",  32'(bus.ram_we), 32'd0);
      check("tbl_hold",    32'({bus.ram_addr, bus.ram_din}), 32'({4'd3, vecs[v].mu[3]}));
      check("tbl_wr_done", 32'(bus.wr_done), 32'd1);
      tick(); @(negedge clk);
      check("tbl_done_1cyc", 32'(bus.wr_done), 32'd0);
      check("tbl_max_clr",   32'({max_addr, max_val}), 32'd0);
      check("tbl_idle",      32'(busy), 32'd0);
    end

    // Four groups eight cycles apart, then ALU_done: 16 writes over the full address range.
    obs_q.delete(); exp_q.delete(); m_addr = '0; d0 = n_done;
    for (int k = 0; k < 4; k++) begin
      g = rand_group();
      send_group(g, 1'b0);
      expect_group(g);
      repeat (5) tick();
    end
    pulse_done();
    repeat (12) tick();
    @(negedge clk);
    compare_obs("four_groups");
    check("four_wr_done", 32'(n_done - d0), 32'd1);

    // Three back-to-back webs into a depth-2 FIFO: the third group is dropped.
    obs_q.delete(); exp_q.delete(); m_addr = '0; d0 = n_done;
    @(negedge clk); check("ovf_before", 32'(ovf), 32'd0);
    ga = rand_group(); gb = rand_group(); gc = rand_group();
    tick(); drive_mu(ga);
    tick(); drive_mu(gb);  bus.web = 1'b1;
    tick(); drive_mu(gc);
    tick(); drive_mu('0);
    tick(); bus.web = 1'b0;
    expect_group(ga);
    expect_group(gb);
    repeat (14) tick();
    @(negedge clk);
    check("ovf_set", 32'(ovf), 32'd1);
    compare_obs("ovf_writes");
    pulse_done();
    repeat (4) tick();
    @(negedge clk);
    check("ovf_wr_done", 32'(n_done - d0), 32'd1);
    check("ovf_sticky",  32'(ovf), 32'd1);

    // Reset during the lane-2 write, then a fresh group must start at address 0.
    obs_q.delete(); exp_q.delete(); m_addr = '0;
    ga = rand_group();
    send_group(ga, 1'b0);
    repeat (4) tick();
    @(negedge clk);
    check("pre_rst_lane2", 32'({bus.ram_addr, bus.ram_din}), 32'({4'd2, ga[2]}));
    #1 rst = 1'b0;
    #1 check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    obs_q.delete();
    gb = rand_group();
    send_group(gb, 1'b0);
    expect_group(gb);
    repeat (8) tick();
    @(negedge clk);
    compare_obs("post_rst");
    pulse_done();
    repeat (4) tick();

    // Random matrices: 1..5 groups, ALU_done with the last web or a few cycles after it.
    for (int m = 0; m < 6; m++) begin
      obs_q.delete(); exp_q.delete(); m_addr = '0; d0 = n_done;
      ng   = int'($urandom_range(1, 5));
      same = 1'($urandom_range(0, 1));
      for (int k = 0; k < ng; k++) begin
        g    = rand_group();
        last = (k == ng - 1);
        send_group(g, last && same);
        expect_group(g);
        if (!last) repeat ($urandom_range(3, 7)) tick();
      end
      if (!same) begin
        repeat ($urandom_range(0, 3)) tick();
        pulse_done();
      end
      repeat (16) tick();
      @(negedge clk);
      compare_obs("rand_writes");
      check("rand_wr_done", 32'(n_done - d0), 32'd1);
      check("rand_idle",    32'(busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter ADDR_W, default 4, output-RAM address width; 2^ADDR_W results per matrix.
REQ-002 Parameter FIFO_DEPTH, default 2, number of buffered 4-result groups.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 MU1..MU4  input  18 each  accumulated dot products from the upstream ALU.
REQ-006 web  input  1  one-cycle pulse: one 4-result group is complete.
REQ-007 ALU_done  input  1  one-cycle pulse: the last group of the matrix is complete.
REQ-008 ram_we  output  1  output-RAM write strobe.
REQ-009 ram_addr  output  ADDR_W  output-RAM write address.
REQ-010 ram_din  output  18  output-RAM write data.
REQ-011 wr_done  output  1  one-cycle pulse: all results of the matrix are written.
REQ-012 busy  output  1  high while the FIFO is non-empty or a drain is in progress.
REQ-013 ovf  output  1  sticky flag: a group was dropped.
REQ-014 max_val  output  18 and max_addr  output  ADDR_W  running maximum and its address (see Configuration).

Function
REQ-015 The block shall register MU1..MU4 into a shadow register every cycle, because upstream clears MU in the same cycle it raises web.
REQ-016 The FIFO shall push the shadow contents {MU1,MU2,MU3,MU4} on any rising clk edge that samples web high.
REQ-017 FSM states: IDLE, DRAIN, DONE.
REQ-018 IDLE->DRAIN when the FIFO is non-empty; DRAIN->IDLE after lane 3 is written with the FIFO empty; DRAIN stays in DRAIN after lane 3 when the FIFO is non-empty.
REQ-019 In DRAIN the block shall write one lane per cycle in the order MU1, MU2, MU3, MU4, with ram_we=1, ram_din=lane and ram_addr=the address counter.
REQ-020 The FIFO head shall pop at lane 3; latency from the web sample to the first ram_we shall be 2 cycles.
REQ-021 The address counter shall increment after each write and wrap from 2^ADDR_W-1 to 0.
REQ-022 ALU_done shall set a pending flag; pending with the FIFO empty and the FSM in IDLE shall move the FSM to DONE.
REQ-023 DONE shall pulse wr_done for one cycle, clear pending, zero the address counter, and return to IDLE.
REQ-024 web and ALU_done in the same cycle shall push the group first; wr_done shall follow its drain.
REQ-025 A push when the FIFO is full and no pop occurs that cycle shall drop the group and set ovf.
REQ-026 A push and a pop in the same cycle when the FIFO is full shall be accepted.
REQ-027 ram_we shall be 0 outside DRAIN, and ram_din and ram_addr shall hold their last values.

Reset
REQ-028 rst low shall asynchronously clear FSM (IDLE), FIFO pointers, shadow, address counter, pending, ram_we, ram_addr, ram_din, wr_done, busy, ovf, max_val and max_addr to 0.
REQ-029 Reset mid-drain shall discard all buffered groups; the first write after reset shall use address 0.

Configuration
REQ-030 With RESULT_MAX_EN defined, each write with ram_din > max_val (unsigned) shall update max_val and max_addr; equal values shall not update.
REQ-031 With RESULT_MAX_EN defined, max_val and max_addr shall clear in DONE.
REQ-032 Without RESULT_MAX_EN, max_val and max_addr shall be constant 0 and no compare logic shall be generated.

Structure
REQ-033 Shared package rw_pkg shall hold RES_W=18, LANES=4, the FSM state encoding and the 72-bit group type.
REQ-034 The FIFO shall be the single sub-module rw_fifo (width 72, depth FIFO_DEPTH, with full and empty outputs).

Verification
REQ-035 Shadow values 1,2,3,4, then web -> writes at addresses 0..3 with data 1,2,3,4 starting 2 cycles later.
REQ-036 Four web pulses 8 cycles apart, then ALU_done -> 16 writes at addresses 0..15, one wr_done, address counter back to 0.
REQ-037 Three web pulses on consecutive cycles with FIFO_DEPTH=2 -> third group dropped, ovf=1, 8 writes.
REQ-038 rst low during the lane-2 write -> all outputs 0 immediately; a next group writes at address 0.
REQ-039 RESULT_MAX_EN with results 5, 9, 9, 3 -> max_val=9, max_addr=1.
REQ-040 web and ALU_done in the same cycle -> 4 writes, then wr_done on the next cycle.
